// File: rtl/fifo_rd_stream_adapter_if.sv
// Read-side bundle between the async FIFO, the stream adapter and the stream consumer.
// The "master" modport is the adapter's view: it pops the FIFO and sources the stream.
// The "slave" modport is the opposite view: the FIFO read port plus the stream consumer.
interface fifo_rd_stream_adapter_if #(
  parameter int unsigned MEMORY_WIDTH = 8
);
  // FIFO first-word-fall-through read port
  logic                    fifo_r_empty;
  logic [MEMORY_WIDTH-1:0] fifo_rdata;
  logic                    fifo_r_en;
  // Registered valid/ready stream
  logic                    m_valid;
  logic [MEMORY_WIDTH-1:0] m_data;
  logic                    m_ready;

  modport master (
    input  fifo_r_empty,
    input  fifo_rdata,
    output fifo_r_en,
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    output fifo_r_empty,
    output fifo_rdata,
    input  fifo_r_en,
    input  m_valid,
    input  m_data,
    output m_ready
  );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// Read-domain adapter from a FWFT FIFO read port to a registered valid/ready stream.
// A 2-entry skid buffer (head + skid) decouples m_ready from fifo_r_en, so the pop
// strobe depends only on FIFO empty, flush and buffer occupancy. A synchronous flush
// discards the buffered words without touching the FIFO.
// Optional popped-word counter (pop_cnt/cnt_clr) is built when FIFO_RD_STREAM_CNT_EN
// is defined.
module fifo_rd_stream_adapter #(
  parameter int unsigned MEMORY_WIDTH = 8
`ifdef FIFO_RD_STREAM_CNT_EN
  , parameter int unsigned CNT_WIDTH = 16
`endif
) (
  input  logic                      r_clk,
  input  logic                      rrst_n,
  input  logic                      flush,
  output logic [1:0]                level,
`ifdef FIFO_RD_STREAM_CNT_EN
  input  logic                      cnt_clr,
  output logic [CNT_WIDTH-1:0]      pop_cnt,
`endif
  fifo_rd_stream_adapter_if.master  bus
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } occ_e;

  occ_e                    occ_q, occ_d;
  logic [MEMORY_WIDTH-1:0] head_q, head_d;
  logic [MEMORY_WIDTH-1:0] skid_q, skid_d;
  logic                    pop;
  logic                    acc;

  // Pop only when there is room; reset gating keeps the strobe low while reset is held.
  assign pop = rrst_n & ~bus.fifo_r_empty & ~flush & (occ_q != StTwo);
  assign acc = bus.m_valid & bus.m_ready;

  assign bus.fifo_r_en = pop;
  assign bus.m_valid   = (occ_q != StEmpty);
  assign bus.m_data    = head_q;
  assign level         = occ_q;

  // Next occupancy and storage contents; flush wins over everything else.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    if (flush) begin
      occ_d = StEmpty;
    end else begin
      unique case (occ_q)
        StEmpty: begin
          if (pop) begin
            head_d = bus.fifo_rdata;
            occ_d  = StOne;
          end
        end
        StOne: begin
          if (pop && acc) begin
            head_d = bus.fifo_rdata;
          end else if (pop) begin
            skid_d = bus.fifo_rdata;
            occ_d  = StTwo;
          end else if (acc) begin
            occ_d = StEmpty;
          end
        end
        StTwo: begin
          if (acc) begin
            head_d = skid_q;
            occ_d  = StOne;
          end
        end
        default: occ_d = StEmpty;
      endcase
    end
  end

  // Buffer state registers; reset drops buffered words immediately.
  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      occ_q  <= StEmpty;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Popped-word count; a clear overrides a same-cycle increment, wraps naturally.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (pop) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pop_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Self-checking bench for fifo_rd_stream_adapter. A queue stands in for the FIFO and a
// second queue models the adapter's buffered words; expectations come from those queues.
module tb_fifo_rd_stream_adapter;
  localparam int unsigned W = 8;

  logic r_clk = 1'b0;
  logic rrst_n;
  logic flush;
  logic [1:0] level;
`ifdef FIFO_RD_STREAM_CNT_EN
  logic       cnt_clr;
  logic [3:0] pop_cnt;
  logic [3:0] cnt_m;
`endif

  fifo_rd_stream_adapter_if #(.MEMORY_WIDTH(W)) bus ();

  fifo_rd_stream_adapter #(
    .MEMORY_WIDTH(W)
`ifdef FIFO_RD_STREAM_CNT_EN
    , .CNT_WIDTH(4)
`endif
  ) dut (
    .r_clk  (r_clk),
    .rrst_n (rrst_n),
    .flush  (flush),
    .level  (level),
`ifdef FIFO_RD_STREAM_CNT_EN
    .cnt_clr(cnt_clr),
    .pop_cnt(pop_cnt),
`endif
    .bus    (bus)
  );

  always #5 r_clk = ~r_clk;

  logic [W-1:0] fq[$];       // FIFO contents, head at index 0
  logic [W-1:0] mb[$];       // words held by the adapter, oldest first
  logic [W-1:0] out_log[$];  // words the consumer accepted
  int           out_cyc[$];  // cycle of each acceptance
  int           cyc = 0;
  int           n_chk = 0;
  int           n_fail = 0;

  function automatic bit model_en();
    return rrst_n && (fq.size() != 0) && !flush && (mb.size() < 2);
  endfunction

  // Present the FIFO head; garbage on the data bus when empty.
  task automatic apply();
    bus.fifo_r_empty = (fq.size() == 0);
    bus.fifo_rdata   = (fq.size() != 0) ? fq[0] : W'($urandom);
  endtask

  // Advance one clock and update the model; returns at the next falling edge.
  task automatic tick();
    bit pop, acc;
    logic [W-1:0] w;
    pop = model_en();
    acc = rrst_n && (mb.size() != 0) && bus.m_ready;
    @(posedge r_clk);
    cyc++;
    if (!rrst_n) begin
      mb.delete();
    end else begin
      if (acc) begin
        out_log.push_back(mb[0]);
        out_cyc.push_back(cyc);
        void'(mb.pop_front());
      end
      if (pop) begin
        w = fq.pop_front();
        mb.push_back(w);
      end
      if (flush) mb.delete();
    end
`ifdef FIFO_RD_STREAM_CNT_EN
    if (!rrst_n || cnt_clr) cnt_m = '0;
    else if (pop) cnt_m = cnt_m + 4'd1;
`endif
    @(negedge r_clk);
    apply();
  endtask

  task automatic test_reset();
    rrst_n = 1'b0;
    flush = 1'b0;
    bus.m_ready = 1'b0;
`ifdef FIFO_RD_STREAM_CNT_EN
    cnt_clr = 1'b0;
    cnt_m = '0;
`endif
    fq.delete();
    fq.push_back(8'h99);
    apply();
    tick();
    #1;
    n_chk++; if (bus.fifo_r_en !== 1'b0) begin n_fail++;
      $display("FAIL rst_en got=%b exp=0", bus.fifo_r_en); end
    n_chk++; if (bus.m_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_valid got=%b exp=0", bus.m_valid); end
    n_chk++; if (level !== 2'd0) begin n_fail++;
      $display("FAIL rst_level got=%0d exp=0", level); end
    n_chk++; if (bus.m_data !== 8'h00) begin n_fail++;
      $display("FAIL rst_data got=%h exp=00", bus.m_data); end
`ifdef FIFO_RD_STREAM_CNT_EN
    n_chk++; if (pop_cnt !== 4'd0) begin n_fail++;
      $display("FAIL rst_cnt got=%0d exp=0", pop_cnt); end
`endif
    tick();
    fq.delete();
    apply();
    rrst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_chk++;
      if (bus.fifo_r_en !== 1'b0 || bus.m_valid !== 1'b0 || level !== 2'd0) begin
        n_fail++;
        $display("FAIL idle cyc=%0d got en=%b valid=%b level=%0d exp 0/0/0",
                 i, bus.fifo_r_en, bus.m_valid, level);
      end
      tick();
    end
  endtask

  task automatic test_stream();
    int n_en = 0;
    out_log.delete();
    out_cyc.delete();
    fq = '{8'h11, 8'h22, 8'h33};
    apply();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (bus.fifo_r_en === 1'b1) n_en++;
      n_chk++; if (bus.fifo_r_en !== model_en()) begin n_fail++;
        $display("FAIL stream_en cyc=%0d got=%b exp=%b", i, bus.fifo_r_en, model_en()); end
      n_chk++; if (level !== 2'(mb.size())) begin n_fail++;
        $display("FAIL stream_level cyc=%0d got=%0d exp=%0d", i, level, mb.size()); end
      if (mb.size() != 0) begin
        n_chk++; if (bus.m_data !== mb[0]) begin n_fail++;
          $display("FAIL stream_data cyc=%0d got=%h exp=%h", i, bus.m_data, mb[0]); end
      end
      tick();
    end
    n_chk++; if (n_en != 3) begin n_fail++;
      $display("FAIL stream_pops got=%0d exp=3", n_en); end
    n_chk++;
    if (out_log.size() != 3 || out_log[0] !== 8'h11 || out_log[1] !== 8'h22 ||
        out_log[2] !== 8'h33 || out_cyc[2] != out_cyc[0] + 2) begin
      n_fail++;
      $display("FAIL stream_order got n=%0d exp 11,22,33 on consecutive cycles", out_log.size());
    end
  endtask

  task automatic test_backpressure();
    int n_en = 0;
    out_log.delete();
    out_cyc.delete();
    fq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    bus.m_ready = 1'b0;
    apply();
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.fifo_r_en === 1'b1) n_en++;
      tick();
    end
    #1;
    n_chk++; if (n_en != 2) begin n_fail++;
      $display("FAIL bp_pops got=%0d exp=2", n_en); end
    n_chk++; if (level !== 2'd2 || bus.fifo_r_en !== 1'b0) begin n_fail++;
      $display("FAIL bp_full got level=%0d en=%b exp level=2 en=0", level, bus.fifo_r_en); end
    n_chk++; if (bus.m_data !== 8'hA0) begin n_fail++;
      $display("FAIL bp_hold got=%h exp=a0", bus.m_data); end
    bus.m_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      if (mb.size() != 0) begin
        n_chk++; if (bus.m_data !== mb[0]) begin n_fail++;
          $display("FAIL bp_data cyc=%0d got=%h exp=%h", i, bus.m_data, mb[0]); end
      end
      tick();
    end
    n_chk++;
    if (out_log.size() != 5) begin
      n_fail++;
      $display("FAIL bp_count got=%0d exp=5", out_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (out_log[i] !== W'(8'hA0 + i) || (i > 0 && out_cyc[i] != out_cyc[i-1] + 1)) begin
          n_fail++;
          $display("FAIL bp_order idx=%0d got=%h exp=%h", i, out_log[i], W'(8'hA0 + i));
          break;
        end
      end
    end
  endtask

  task automatic test_flush();
    fq = '{8'h55, 8'h66, 8'h77, 8'h88};
    bus.m_ready = 1'b0;
    apply();
    tick();
    tick();
    #1;
    n_chk++; if (level !== 2'd2) begin n_fail++;
      $display("FAIL fl_pre_level got=%0d exp=2", level); end
    flush = 1'b1;
    bus.m_ready = 1'b1;
    #1;
    n_chk++; if (bus.fifo_r_en !== 1'b0) begin n_fail++;
      $display("FAIL fl_en got=%b exp=0", bus.fifo_r_en); end
    tick();
    flush = 1'b0;
    bus.m_ready = 1'b0;
    out_log.delete();
    out_cyc.delete();
    #1;
    n_chk++; if (bus.m_valid !== 1'b0 || level !== 2'd0) begin n_fail++;
      $display("FAIL fl_post got valid=%b level=%0d exp 0/0", bus.m_valid, level); end
    bus.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_chk++; if (out_log.size() != 2 || out_log[0] !== 8'h77 || out_log[1] !== 8'h88) begin
      n_fail++;
      $display("FAIL fl_next got n=%0d first=%h exp 77,88", out_log.size(),
               (out_log.size() != 0) ? out_log[0] : 8'h00);
    end
  endtask

  task automatic test_async_reset();
    fq = '{8'hC1, 8'hC2, 8'hC3};
    bus.m_ready = 1'b0;
    apply();
    tick();
    tick();
    #1;
    n_chk++; if (level !== 2'd2 || bus.m_valid !== 1'b1) begin n_fail++;
      $display("FAIL ar_pre got level=%0d valid=%b exp 2/1", level, bus.m_valid); end
    #1;
    rrst_n = 1'b0;
    #1;
    n_chk++; if (bus.m_valid !== 1'b0 || level !== 2'd0 || bus.fifo_r_en !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_async got valid=%b level=%0d en=%b exp 0/0/0",
               bus.m_valid, level, bus.fifo_r_en);
    end
    tick();
    fq.delete();
    apply();
    rrst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (fq.size() < 8 && ($urandom_range(0, 1) == 1)) fq.push_back(W'($urandom));
      bus.m_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      apply();
      #1;
      n_chk++;
      if (bus.fifo_r_en !== model_en() || bus.m_valid !== (mb.size() != 0) ||
          level !== 2'(mb.size()) || (mb.size() != 0 && bus.m_data !== mb[0])) begin
        n_fail++;
        $display("FAIL rand cyc=%0d got en=%b valid=%b level=%0d data=%h exp en=%b level=%0d data=%h",
                 i, bus.fifo_r_en, bus.m_valid, level, bus.m_data, model_en(), mb.size(),
                 (mb.size() != 0) ? mb[0] : 8'h00);
      end
      tick();
    end
    flush = 1'b0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
  endtask

`ifdef FIFO_RD_STREAM_CNT_EN
  task automatic test_counter();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    #1;
    n_chk++; if (pop_cnt !== 4'd0) begin n_fail++;
      $display("FAIL cnt_clr0 got=%0d exp=0", pop_cnt); end
    for (int i = 0; i < 17; i++) fq.push_back(W'(i));
    bus.m_ready = 1'b1;
    apply();
    for (int i = 0; i < 20; i++) tick();
    #1;
    n_chk++; if (pop_cnt !== 4'd1 || cnt_m !== 4'd1) begin n_fail++;
      $display("FAIL cnt_wrap got=%0d exp=1", pop_cnt); end
    fq.push_back(8'hEE);
    apply();
    cnt_clr = 1'b1;
    #1;
    n_chk++; if (bus.fifo_r_en !== 1'b1) begin n_fail++;
      $display("FAIL cnt_pop_en got=%b exp=1", bus.fifo_r_en); end
    tick();
    cnt_clr = 1'b0;
    #1;
    n_chk++; if (pop_cnt !== 4'd0) begin n_fail++;
      $display("FAIL cnt_clr_prio got=%0d exp=0", pop_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
`ifdef FIFO_RD_STREAM_CNT_EN
    test_counter();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
